// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap CSRs, privilege tracking and stall/flush/redirect sequencing
module trap_controller #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_exception,
  input  logic            i_mret,
  input  logic [3:0]      i_causeNum,
  input  logic            i_extIrq,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_csrWe,
  input  logic [11:0]     i_csrAddr,
  input  logic [XLEN-1:0] i_csrWdata,
  output logic [XLEN-1:0] o_csrRdata,
  output logic [1:0]      o_privMode,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirectPC
);
  typedef enum logic [1:0] {IDLE, TRAP, RET, REDIR} state_t;
  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-5){1'b0}}, 4'hB};
  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;
  state_t state_q, state_d;
  logic [1:0] priv_q, priv_d, mpp_q, mpp_d;
  logic mie_q, mie_d, mpie_q, mpie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d, target_q, target_d;
  logic [XLEN-1:0] mstatus;
  logic idle, irq_en, take_exc, take_irq, take_ret, csr_wr;
  // event acceptance in priority order and the CSR write gate that yields to any accepted event
  always_comb begin
    idle     = state_q == IDLE;
    irq_en   = i_extIrq && (mie_q || priv_q == PRIV_U);
    take_exc = idle && i_exception;
    take_irq = idle && !i_exception && irq_en;
    take_ret = idle && !i_exception && !irq_en && i_mret && priv_q == PRIV_M;
    csr_wr   = idle && i_csrWe && !(take_exc || take_irq || take_ret);
  end
  // mstatus view and combinational CSR read mux; unmapped addresses read zero
  always_comb begin
    mstatus = '0;
    mstatus[12:11] = mpp_q;
    mstatus[7] = mpie_q;
    mstatus[3] = mie_q;
    o_csrRdata = i_csrAddr == 12'h300 ? mstatus :
                 i_csrAddr == 12'h305 ? mtvec_q :
                 i_csrAddr == 12'h341 ? mepc_q :
                 i_csrAddr == 12'h342 ? mcause_q : '0;
  end
  // next-state: event capture in IDLE, mstatus stacking in TRAP/RET, single redirect pulse
  always_comb begin
    state_d  = state_q;
    priv_d   = priv_q;
    mpp_d    = mpp_q;
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    target_d = target_q;
    if (take_exc || take_irq) begin
      mepc_d   = {i_pc[XLEN-1:2], 2'b00};
      mcause_d = take_exc ? XLEN'(i_causeNum) : IRQ_CAUSE;
      state_d  = TRAP;
    end else if (take_ret) begin
      state_d = RET;
    end else if (csr_wr) begin
      if (i_csrAddr == 12'h300) begin
        mie_d  = i_csrWdata[3];
        mpie_d = i_csrWdata[7];
        mpp_d  = i_csrWdata[12:11] == PRIV_M ? PRIV_M : PRIV_U;
      end
      if (i_csrAddr == 12'h305) mtvec_d = {i_csrWdata[XLEN-1:2], 2'b00};
      if (i_csrAddr == 12'h341) mepc_d = {i_csrWdata[XLEN-1:2], 2'b00};
      if (i_csrAddr == 12'h342) mcause_d = i_csrWdata;
    end
    if (state_q == TRAP) begin
      mpie_d   = mie_q;
      mie_d    = 1'b0;
      mpp_d    = priv_q;
      priv_d   = PRIV_M;
      target_d = mtvec_q;
      state_d  = REDIR;
    end
    if (state_q == RET) begin
      mie_d    = mpie_q;
      mpie_d   = 1'b1;
      priv_d   = mpp_q;
      mpp_d    = PRIV_U;
      target_d = mepc_q;
      state_d  = REDIR;
    end
    if (state_q == REDIR) state_d = IDLE;
  end
  // state and CSR registers with synchronous reset that also aborts any sequence in flight
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      priv_q   <= PRIV_M;
      mpp_q    <= PRIV_U;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= {MTVEC_RESET[XLEN-1:2], 2'b00};
      mepc_q   <= '0;
      mcause_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      priv_q   <= priv_d;
      mpp_q    <= mpp_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      target_q <= target_d;
    end
  end
  assign o_privMode   = priv_q;
  assign o_stall      = state_q != IDLE;
  assign o_flush      = state_q == TRAP || state_q == RET;
  assign o_redirect   = state_q == REDIR;
  assign o_redirectPC = target_q;
endmodule

// File: tb/tb_trap_controller.sv
// tb_trap_controller: directed trap/mret/interrupt vectors with a redirect scoreboard
module tb_trap_controller;
  logic        clk = 1'b0;
  logic        rst, exc, mret, irq, we;
  logic [3:0]  cause;
  logic [31:0] pc, wdata, rdata, rpc;
  logic [11:0] addr;
  logic [1:0]  priv;
  logic        stall, flush, redir;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  trap_controller #(.XLEN(32), .MTVEC_RESET(32'h0000_0207)) dut (
    .i_clk(clk), .i_rst(rst), .i_exception(exc), .i_mret(mret), .i_causeNum(cause),
    .i_extIrq(irq), .i_pc(pc), .i_csrWe(we), .i_csrAddr(addr), .i_csrWdata(wdata),
    .o_csrRdata(rdata), .o_privMode(priv), .o_stall(stall), .o_flush(flush),
    .o_redirect(redir), .o_redirectPC(rpc)
  );
  always #5 clk = ~clk;
  // scoreboard monitor: every redirect pulse must match the next queued target
  always @(negedge clk) begin
    if (redir) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL redirect_unexpected got=%h want=none", rpc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (rpc !== e) begin
          errors++;
          $display("FAIL redirect_pc got=%h want=%h", rpc, e);
        end
      end
    end
  end
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask
  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] want);
    addr = a;
    #1;
    chk(name, rdata, want);
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask
  task automatic strobes(input string name, input logic [2:0] want);
    chk(name, {29'd0, stall, flush, redir}, {29'd0, want});
  endtask
  initial begin
    rst = 1'b1; exc = 0; mret = 0; irq = 0; we = 0; cause = 0; pc = 0; wdata = 0; addr = 0;
    tick(); tick();
    rst = 1'b0;
    rd("rst_mtvec", 12'h305, 32'h0000_0204);
    rd("rst_mstatus", 12'h300, 32'h0);
    rd("rst_mepc", 12'h341, 32'h0);
    chk("rst_priv", {30'd0, priv}, 32'd3);
    strobes("rst_strobes", 3'b000);
    chk("rst_rpc", rpc, 32'h0);
    wr(12'h305, 32'h0000_0103);
    rd("mtvec_wr", 12'h305, 32'h0000_0100);
    wr(12'h300, 32'h0000_0008);
    exc = 1; cause = 4'd8; pc = 32'h0000_0041;
    exp_q.push_back(32'h0000_0100);
    tick();
    exc = 0;
    strobes("exc_trap_cycle", 3'b110);
    tick();
    strobes("exc_redir_cycle", 3'b101);
    tick();
    strobes("exc_idle", 3'b000);
    rd("exc_mepc", 12'h341, 32'h0000_0040);
    rd("exc_mcause", 12'h342, 32'h0000_0008);
    rd("exc_mstatus", 12'h300, 32'h0000_1880);
    chk("exc_priv", {30'd0, priv}, 32'd3);
    wr(12'h300, 32'h0000_0080);
    mret = 1;
    exp_q.push_back(32'h0000_0040);
    tick();
    mret = 0;
    strobes("ret_cycle", 3'b110);
    tick();
    chk("ret_priv_u", {30'd0, priv}, 32'd0);
    tick();
    rd("ret_mstatus", 12'h300, 32'h0000_0088);
    mret = 1;
    tick();
    mret = 0;
    strobes("mret_in_u_ignored", 3'b000);
    irq = 1; exc = 1; cause = 4'd2; pc = 32'h0000_0080;
    exp_q.push_back(32'h0000_0100);
    tick();
    exc = 0;
    tick(); tick();
    rd("prio_mcause", 12'h342, 32'h0000_0002);
    rd("prio_mepc", 12'h341, 32'h0000_0080);
    rd("prio_mstatus", 12'h300, 32'h0000_0080);
    strobes("irq_masked", 3'b000);
    pc = 32'h0000_00C6;
    exp_q.push_back(32'h0000_0100);
    wr(12'h300, 32'h0000_0088);
    tick();
    irq = 0;
    strobes("irq_trap_cycle", 3'b110);
    tick(); tick();
    rd("irq_mcause", 12'h342, 32'h8000_000B);
    rd("irq_mepc", 12'h341, 32'h0000_00C4);
    rd("irq_mstatus", 12'h300, 32'h0000_1880);
    we = 1; addr = 12'h305; wdata = 32'h0000_0200;
    exc = 1; cause = 4'd5; pc = 32'h0000_0010;
    exp_q.push_back(32'h0000_0100);
    tick();
    we = 0; exc = 0;
    tick(); tick();
    rd("drop_mtvec", 12'h305, 32'h0000_0100);
    rd("drop_mcause", 12'h342, 32'h0000_0005);
    wr(12'h300, 32'h0000_0800);
    rd("mpp_01", 12'h300, 32'h0);
    wr(12'h300, 32'h0000_1000);
    rd("mpp_10", 12'h300, 32'h0);
    wr(12'h300, 32'hFFFF_FFFF);
    rd("mstatus_mask", 12'h300, 32'h0000_1888);
    wr(12'h342, 32'hDEAD_BEEF);
    rd("mcause_full", 12'h342, 32'hDEAD_BEEF);
    wr(12'h123, 32'h1234_5678);
    rd("unmapped", 12'h123, 32'h0);
    exc = 1; cause = 4'd3; pc = 32'h0000_0020;
    tick();
    exc = 0;
    strobes("abort_trap_cycle", 3'b110);
    rst = 1;
    tick();
    rst = 0;
    strobes("abort_idle", 3'b000);
    chk("abort_rpc", rpc, 32'h0);
    rd("abort_mepc", 12'h341, 32'h0);
    rd("abort_mtvec", 12'h305, 32'h0000_0204);
    rd("abort_mstatus", 12'h300, 32'h0);
    chk("abort_priv", {30'd0, priv}, 32'd3);
    tick(); tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
